// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default geometry and a depth helper
// so every file derives the register count the same way.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    function automatic int depth_of(input int addr_w);
        return 2 ** addr_w;
    endfunction

    localparam int DEPTH = depth_of(DEFAULT_ADDR_W);

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue and cleared on write-back.
// Also raises the sticky protocol-error flag.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NREGS    = DEPTH,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    output logic [NREGS-1:0]  busy,
    output logic              err
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             err_q, err_d;
    logic             wb_hits_dst, waw, spur0, spur1, dual;

    // A new issue supersedes a write-back landing on the same register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (iss_valid && (iss_dst == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)))) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        wb_hits_dst = (we0 && (wa0 == iss_dst)) || (we1 && (wa1 == iss_dst));
        waw         = iss_valid && busy_q[iss_dst] && !wb_hits_dst;
        spur0       = we0 && !busy_q[wa0] && !(ZERO_REG && (wa0 == '0));
        spur1       = we1 && !busy_q[wa1] && !(ZERO_REG && (wa1 == '0));
        dual        = we0 && we1 && (wa0 == wa1) && (wa0 != '0);
        err_d       = err_q || waw || spur0 || spur1 || dual;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two prioritised write-back ports, NRD combinational read
// ports with optional bypass, and a busy scoreboard for operand readiness.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_dst,
    output logic                  err
);

    localparam int NREGS = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic [NREGS-1:0]  busy;

    // Port 1 (memory) is applied last so it wins a same-index collision.
    always_comb begin
        mem_d = mem_q;
        if (we0) begin
            mem_d[wa0] = wd0;
        end
        if (we1) begin
            mem_d[wa1] = wd1;
        end
        if (ZERO_REG) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .we0       (we0),
        .wa0       (wa0),
        .we1       (we1),
        .wa1       (wa1),
        .busy      (busy),
        .err       (err)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              hit0, hit1;

        assign idx  = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit0 = we0 && (wa0 == idx);
        assign hit1 = we1 && (wa1 == idx);

        assign rd_data[k*DATA_W +: DATA_W] = (ZERO_REG && (idx == '0)) ? '0  :
                                             (BYPASS && hit1)           ? wd1 :
                                             (BYPASS && hit0)           ? wd0 :
                                             mem_q[idx];

        // A write-back landing this cycle already satisfies a bypassed read.
        assign rd_busy[k] = busy[idx] && !(BYPASS && (hit0 || hit1));
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: instance A uses ZERO_REG=1/BYPASS=1, instance B
// uses ZERO_REG=0/BYPASS=0, both driven by the same stimulus.
module tb_regfile_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic              we0, we1, iss_valid;
    logic [AW-1:0]     wa0, wa1, iss_dst;
    logic [DW-1:0]     wd0, wd1;

    logic [NRD*DW-1:0] rd_data_a, rd_data_b;
    logic [NRD-1:0]    rd_busy_a, rd_busy_b;
    logic              err_a, err_b;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .err(err_a)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .err(err_b)
    );

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle's worth of issue and write-back inputs.
    task automatic applyStimulus(input logic iv, input logic [AW-1:0] dst,
                                 input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        iss_valid = iv;
        iss_dst   = dst;
        we0       = e0;
        wa0       = a0;
        wd0       = d0;
        we1       = e1;
        wa1       = a1;
        wd1       = d1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic setRead(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        rd_addr = {p1, p0};
    endtask

    // Advances to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] dataA(input int k);
        return rd_data_a[k*DW +: DW];
    endfunction

    function automatic logic [31:0] dataB(input int k);
        return rd_data_b[k*DW +: DW];
    endfunction

    // Directed scenarios; each block below states the behaviour being exercised.
    initial begin
        rst = 1'b1;
        idle();
        setRead(5'd5, 5'd0);
        #2;
        checkOutput("reset_data_a", dataA(0), 32'h0);
        checkOutput("reset_busy_a", 32'(rd_busy_a), 32'h0);
        checkOutput("reset_err_a", 32'(err_a), 32'h0);
        checkOutput("reset_err_b", 32'(err_b), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write r5, then reset with a write still pending.
        applyStimulus(1'b1, 5'd5, 1'b0, '0, '0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        step();
        idle();
        #1;
        checkOutput("r5_written_a", dataA(0), 32'hDEADBEEF);
        checkOutput("r5_written_b", dataB(0), 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd5, 32'h0BADF00D, 1'b0, '0, '0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle();
        #1;
        checkOutput("midrst_data_a", dataA(0), 32'h0);
        checkOutput("midrst_data_b", dataB(0), 32'h0);
        checkOutput("midrst_busy_a", 32'(rd_busy_a), 32'h0);
        checkOutput("midrst_busy_b", 32'(rd_busy_b), 32'h0);
        checkOutput("midrst_err_a", 32'(err_a), 32'h0);
        checkOutput("midrst_err_b", 32'(err_b), 32'h0);
        rst = 1'b0;
        step();

        // Issue r3 in cycle 0, write back in cycle 2.
        setRead(5'd3, 5'd5);
        applyStimulus(1'b1, 5'd3, 1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("c0_busy_a", 32'(rd_busy_a[0]), 32'h0);
        step();
        idle();
        #1;
        checkOutput("c1_busy_a", 32'(rd_busy_a[0]), 32'h1);
        checkOutput("c1_busy_b", 32'(rd_busy_b[0]), 32'h1);
        step();
        applyStimulus(1'b0, '0, 1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
        #1;
        checkOutput("c2_data_a", dataA(0), 32'h11);
        checkOutput("c2_busy_a", 32'(rd_busy_a[0]), 32'h0);
        checkOutput("c2_data_b", dataB(0), 32'h0);
        checkOutput("c2_busy_b", 32'(rd_busy_b[0]), 32'h1);
        step();
        idle();
        #1;
        checkOutput("c3_data_b", dataB(0), 32'h11);
        checkOutput("c3_busy_b", 32'(rd_busy_b[0]), 32'h0);
        checkOutput("c3_data_a", dataA(0), 32'h11);
        checkOutput("c3_err_a", 32'(err_a), 32'h0);
        checkOutput("c3_err_b", 32'(err_b), 32'h0);

        // Both ports write busy r7 in the same cycle.
        setRead(5'd7, 5'd3);
        applyStimulus(1'b1, 5'd7, 1'b0, '0, '0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b0, '0, 1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        #1;
        checkOutput("dual_bypass_a", dataA(0), 32'hBBBB);
        step();
        idle();
        #1;
        checkOutput("dual_data_a", dataA(0), 32'hBBBB);
        checkOutput("dual_data_b", dataB(0), 32'hBBBB);
        checkOutput("dual_other_a", dataA(1), 32'h11);
        checkOutput("dual_err_a", 32'(err_a), 32'h1);
        checkOutput("dual_err_b", 32'(err_b), 32'h1);
        resetDut();

        // Re-issue and write-back to busy r9 in the same cycle.
        setRead(5'd9, 5'd0);
        applyStimulus(1'b1, 5'd9, 1'b0, '0, '0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
        #1;
        checkOutput("r9_same_busy_a", 32'(rd_busy_a[0]), 32'h0);
        checkOutput("r9_same_busy_b", 32'(rd_busy_b[0]), 32'h1);
        step();
        idle();
        #1;
        checkOutput("r9_after_busy_a", 32'(rd_busy_a[0]), 32'h1);
        checkOutput("r9_after_busy_b", 32'(rd_busy_b[0]), 32'h1);
        checkOutput("r9_data_a", dataA(0), 32'h99);
        checkOutput("r9_err_a", 32'(err_a), 32'h0);
        checkOutput("r9_err_b", 32'(err_b), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h98);
        step();
        idle();
        #1;
        checkOutput("r9_clear_busy_a", 32'(rd_busy_a[0]), 32'h0);
        checkOutput("r9_clear_busy_b", 32'(rd_busy_b[0]), 32'h0);
        checkOutput("r9_final_data_b", dataB(0), 32'h98);
        checkOutput("r9_clear_err_a", 32'(err_a), 32'h0);
        resetDut();

        // Register 0: hardwired in A, ordinary in B.
        setRead(5'd0, 5'd0);
        applyStimulus(1'b1, 5'd0, 1'b0, '0, '0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, '0, '0);
        #1;
        checkOutput("r0_busy_pre_a", 32'(rd_busy_a[0]), 32'h0);
        checkOutput("r0_busy_pre_b", 32'(rd_busy_b[0]), 32'h1);
        checkOutput("r0_bypass_a", dataA(0), 32'h0);
        step();
        idle();
        #1;
        checkOutput("r0_data_a", dataA(0), 32'h0);
        checkOutput("r0_data_b", dataB(0), 32'h1234);
        checkOutput("r0_busy_b", 32'(rd_busy_b[0]), 32'h0);
        checkOutput("r0_err_a", 32'(err_a), 32'h0);
        checkOutput("r0_err_b", 32'(err_b), 32'h0);
        resetDut();

        // Spurious write-back to idle r12 still lands, and err sticks.
        setRead(5'd12, 5'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 32'hC0DE0012);
        #1;
        checkOutput("r12_bypass_a", dataA(0), 32'hC0DE0012);
        checkOutput("r12_err_pre_a", 32'(err_a), 32'h0);
        step();
        idle();
        #1;
        checkOutput("r12_err_a", 32'(err_a), 32'h1);
        checkOutput("r12_err_b", 32'(err_b), 32'h1);
        checkOutput("r12_data_a", dataA(0), 32'hC0DE0012);
        checkOutput("r12_data_b", dataB(0), 32'hC0DE0012);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        checkOutput("r12_sticky_a", 32'(err_a), 32'h1);
        resetDut();
        #1;
        checkOutput("r12_cleared_a", 32'(err_a), 32'h0);
        checkOutput("r12_cleared_b", 32'(err_b), 32'h0);

        // Second issue to a still-busy register is a WAW hazard.
        setRead(5'd4, 5'd0);
        applyStimulus(1'b1, 5'd4, 1'b0, '0, '0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b1, 5'd4, 1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checkOutput("waw_err_pre_a", 32'(err_a), 32'h0);
        step();
        idle();
        #1;
        checkOutput("waw_err_a", 32'(err_a), 32'h1);
        checkOutput("waw_err_b", 32'(err_b), 32'h1);
        checkOutput("waw_busy_a", 32'(rd_busy_a[0]), 32'h1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with per-register busy scoreboard, two prioritised write-back ports, N combinational read ports with optional write-to-read bypass, and asynchronous clear. It succeeds the single-write, two-read MIPS register heap in the datapath. It sits between decode (read and issue side) and the ALU/memory write-back stages, and gives decode the operand-ready information it needs for load-use and multi-cycle stalls.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1, write data is forwarded to same-cycle reads

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NRD*ADDR_W  read indices; port k uses slice [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, packed the same way as rd_addr
- rd_busy  out  NRD  1 = the operand's producer has not yet written back
- we0 / wa0 / wd0  in  1 / ADDR_W / DATA_W  write-back port 0 (ALU)
- we1 / wa1 / wd1  in  1 / ADDR_W / DATA_W  write-back port 1 (memory); higher priority
- iss_valid  in  1  an instruction writing iss_dst is issued this cycle
- iss_dst  in  ADDR_W  destination register of the issued instruction
- err  out  1  sticky protocol-error flag

## Operation
- Storage: array of 2**ADDR_W × DATA_W registers, plus one busy bit per register.
- Write: at posedge, if weX is set, the array entry at waX takes wdX.
  - If both ports write the same index, wd1 is stored.
  - With ZERO_REG=1, writes to index 0 are discarded.
- Busy bits, evaluated per register at each posedge:
  - Set when iss_valid and iss_dst equal the index.
  - Otherwise cleared when any weX hits the index.
  - Issue and write-back to the same index in the same cycle: busy stays 1, because the new producer supersedes the old one.
  - With ZERO_REG=1, issue to index 0 is ignored.
- Read data for port k is combinational, chosen in priority order:
  1. ZERO_REG=1 and index 0: returns 0.
  2. BYPASS=1 and we1 hits the index: returns wd1.
  3. BYPASS=1 and we0 hits the index: returns wd0.
  4. Otherwise: returns the array entry.
- rd_busy[k]:
  - With BYPASS=1: busy[idx] AND NOT(any weX hits idx this cycle).
  - With BYPASS=0: busy[idx].
  - The iss_valid of the current cycle has no effect on rd_busy.
- err is set at posedge and cleared only by rst. It is set on any of:
  - iss_valid to an index that is already busy and not being written this cycle (a WAW hazard the issue logic should have stalled).
  - weX to an index whose busy bit is 0 (a spurious write-back; index 0 is exempt when ZERO_REG=1).
  - we0 and we1 to the same nonzero index in the same cycle.

## Timing
- Reset (rst=1, asynchronous): all entries 0, all busy bits 0, err 0. Outputs therefore show rd_data=0, rd_busy=0, err=0.
- Deassertion of rst is sampled synchronously. Reset asserted mid-operation discards any pending writes in that cycle.
- Write latency: 0 cycles to a bypassed read; 1 cycle (visible after the posedge) with BYPASS=0.
- Busy latency: set by issue in cycle t, visible on rd_busy from cycle t+1. Cleared by write-back in cycle t, deasserted in cycle t with BYPASS=1, or from cycle t+1 with BYPASS=0.
- No handshake back-pressure: all inputs are accepted every cycle. Stalling is decode's responsibility, based on rd_busy.

## Structure
- Package regfile_pkg holds the default DATA_W/ADDR_W constants and the localparam DEPTH = 2**ADDR_W.
- Sub-module rf_scoreboard holds the busy-bit array, set/clear priority and err generation. The data array, write-priority logic and read/bypass muxes stay in regfile_sb.
- Read ports are produced by a generate loop over NRD.

## Test plan
- Reset mid-traffic: write 0xDEADBEEF to r5, then assert rst → r5 reads 0, all rd_busy 0, err 0.
- Issue r3 in cycle 0; we0 with wa0=3, wd0=0x11 in cycle 2 → rd_busy 1 in cycle 1. In cycle 2, rd_data=0x11 and rd_busy=0 with BYPASS=1. With BYPASS=0, busy and stale data persist until cycle 3.
- Same-cycle write conflict: we0 (r7, 0xAAAA) and we1 (r7, 0xBBBB) with r7 busy → r7 = 0xBBBB next cycle, err=1.
- Issue and write-back to r9 in the same cycle, with r9 busy → busy remains 1 and err stays 0.
- ZERO_REG=1: write 0x1234 to r0 and issue r0 → r0 reads 0, rd_busy=0, err=0. With ZERO_REG=0, the same stimulus makes r0 read 0x1234 (write performed after an issue to r0).
- Spurious write-back to non-busy r12 → err=1 and stays 1 until rst; the data is still written.
